// File: rtl/snake_step_scheduler.sv
// Snake head sequencer: generates the periodic game-step pulse and applies
// buffered direction commands (at most one per step), rejecting reversals.
module snake_step_scheduler #(
  parameter int BASE_PERIOD = 12_500_000,
  parameter int CNT_W       = 24,
  parameter int QDEPTH      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [1:0] key_dir,
  input  logic       start,
  input  logic       pause,
  input  logic       game_over,
  input  logic [1:0] speed_sel,
  output logic       step,
  output logic [1:0] direction,
  output logic       running,
  output logic       queue_full,
  output logic       drop
);

  localparam int               OCC_W    = $clog2(QDEPTH + 1);
  localparam logic [CNT_W-1:0] BASE     = CNT_W'(BASE_PERIOD);
  localparam logic [OCC_W-1:0] FULL     = OCC_W'(QDEPTH);
  localparam logic [1:0]       DIR_DOWN = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    OVER
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d;
  logic             step_q, step_d;
  logic             drop_q, drop_d;
  logic [1:0]       queue_q [QDEPTH];
  logic [1:0]       queue_d [QDEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;

  logic [CNT_W-1:0] periodM1;
  logic             terminal;
  logic             popAvail;
  logic [1:0]       tailDir;
  logic             keyReject;
  logic             popNow;
  logic             pushNow;
  logic [OCC_W-1:0] occAfterPop;

  // The reference for reversal/duplicate checks is the last queued command,
  // so a burst of keys is validated as a chain rather than against the head.
  always_comb begin
    periodM1 = (BASE >> speed_sel) - CNT_W'(1);
    terminal = (cnt_q >= periodM1);
    popAvail = terminal && (occ_q != '0);
    tailDir  = dir_q;
    for (int i = 0; i < QDEPTH; i++) begin
      if (OCC_W'(i + 1) == occ_q) tailDir = queue_q[i];
    end
    keyReject = (key_dir == tailDir)
             || ((key_dir[1] == tailDir[1]) && (key_dir[0] != tailDir[0]))
             || ((occ_q == FULL) && !popAvail);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    step_d      = 1'b0;
    drop_d      = 1'b0;
    queue_d     = queue_q;
    occ_d       = occ_q;
    popNow      = 1'b0;
    pushNow     = 1'b0;
    occAfterPop = occ_q;
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          occ_d   = '0;
          dir_d   = DIR_DOWN;
        end
      end
      RUN: begin
        if (game_over) begin
          state_d = OVER;
          occ_d   = '0;
        end else if (pause) begin
          state_d = PAUSED;
        end else begin
          if (terminal) begin
            cnt_d  = '0;
            step_d = 1'b1;
            popNow = popAvail;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          pushNow = key_valid && !keyReject;
          drop_d  = key_valid && keyReject;
          // Pop shifts the queue toward the head before any push lands at the tail.
          if (popNow) begin
            dir_d = queue_q[0];
            for (int i = 0; i < QDEPTH - 1; i++) queue_d[i] = queue_q[i + 1];
            occAfterPop = occ_q - OCC_W'(1);
          end
          if (pushNow) begin
            for (int i = 0; i < QDEPTH; i++) begin
              if (OCC_W'(i) == occAfterPop) queue_d[i] = key_dir;
            end
          end
          occ_d = pushNow ? occAfterPop + OCC_W'(1) : occAfterPop;
        end
      end
      PAUSED: begin
        if (game_over) begin
          state_d = OVER;
          occ_d   = '0;
        end else if (pause) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_DOWN;
      step_q  <= 1'b0;
      drop_q  <= 1'b0;
      occ_q   <= '0;
      for (int i = 0; i < QDEPTH; i++) queue_q[i] <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      drop_q  <= drop_d;
      occ_q   <= occ_d;
      queue_q <= queue_d;
    end
  end

  assign step       = step_q;
  assign direction  = dir_q;
  assign drop       = drop_q;
  assign running    = (state_q == RUN);
  assign queue_full = (occ_q == FULL);

endmodule

// File: tb/tb_snake_step_scheduler.sv
// Self-checking bench for snake_step_scheduler: directed scenarios followed by
// random traffic, all compared against a queue-based behavioural model.
module tb_snake_step_scheduler;

  localparam int BASE_PERIOD = 8;
  localparam int CNT_W       = 4;
  localparam int QDEPTH      = 2;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_OVER   = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [1:0] key_dir;
  logic       start;
  logic       pause;
  logic       game_over;
  logic [1:0] speed_sel;
  logic       step;
  logic [1:0] direction;
  logic       running;
  logic       queue_full;
  logic       drop;

  snake_step_scheduler #(
    .BASE_PERIOD(BASE_PERIOD),
    .CNT_W      (CNT_W),
    .QDEPTH     (QDEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_dir   (key_dir),
    .start     (start),
    .pause     (pause),
    .game_over (game_over),
    .speed_sel (speed_sel),
    .step      (step),
    .direction (direction),
    .running   (running),
    .queue_full(queue_full),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Behavioural model state: what the game should look like after each edge.
  int         mState;
  int         mCnt;
  logic [1:0] mDir;
  logic [1:0] mQ[$];
  logic       mStep;
  logic       mDrop;

  logic       rstN;
  logic [1:0] speedSel;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int periodOf(input logic [1:0] sp);
    return BASE_PERIOD >> sp;
  endfunction

  // One clock of game rules: reset, start/pause/game-over, step timing and key queueing.
  task automatic modelStep(input logic kv, input logic [1:0] kd, input logic st,
                           input logic pa, input logic go);
    logic [1:0] refDir;
    logic [1:0] diff;
    bit         popNow;
    bit         reject;
    mStep = 1'b0;
    mDrop = 1'b0;
    if (!rstN) begin
      mState = M_IDLE;
      mCnt   = 0;
      mDir   = 2'b01;
      mQ.delete();
    end else if (mState == M_IDLE || mState == M_OVER) begin
      if (st) begin
        mState = M_RUN;
        mCnt   = 0;
        mDir   = 2'b01;
        mQ.delete();
      end
    end else if (mState == M_PAUSED) begin
      if (go) begin
        mState = M_OVER;
        mQ.delete();
      end else if (pa) begin
        mState = M_RUN;
      end
    end else begin
      if (go) begin
        mState = M_OVER;
        mQ.delete();
      end else if (pa) begin
        mState = M_PAUSED;
      end else begin
        popNow = 0;
        if (mCnt >= periodOf(speedSel) - 1) begin
          mCnt   = 0;
          mStep  = 1'b1;
          popNow = (mQ.size() > 0);
        end else begin
          mCnt = mCnt + 1;
        end
        refDir = (mQ.size() > 0) ? mQ[$] : mDir;
        diff   = kd ^ refDir;
        reject = (kd == refDir) || (diff == 2'b01) || (mQ.size() == QDEPTH && !popNow);
        if (popNow) mDir = mQ.pop_front();
        if (kv) begin
          if (reject) mDrop = 1'b1;
          else        mQ.push_back(kd);
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic kv, input logic [1:0] kd, input logic st,
                               input logic pa, input logic go);
    @(negedge clk);
    reset     = rstN;
    key_valid = kv;
    key_dir   = kd;
    start     = st;
    pause     = pa;
    game_over = go;
    speed_sel = speedSel;
    modelStep(kv, kd, st, pa, go);
    @(posedge clk);
    #1;
    checkOutput("step", step, mStep);
    checkOutput("direction", direction, mDir);
    checkOutput("running", running, mState == M_RUN);
    checkOutput("queue_full", queue_full, mQ.size() == QDEPTH);
    checkOutput("drop", drop, mDrop);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic waitCnt(input int target);
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (mState == M_RUN && mCnt == target) found = 1;
      else idle(1);
    end
    checkOutput("waitCnt", found, 1);
  endtask

  task automatic waitTerminal();
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (mState == M_RUN && mCnt >= periodOf(speedSel) - 1) found = 1;
      else idle(1);
    end
    checkOutput("waitTerminal", found, 1);
  endtask

  initial begin
    logic [1:0] kd;
    reset     = 1'b0;
    key_valid = 1'b0;
    key_dir   = 2'b00;
    start     = 1'b0;
    pause     = 1'b0;
    game_over = 1'b0;
    speed_sel = 2'b00;
    rstN      = 1'b0;
    speedSel  = 2'b00;

    // Reset then start: steps every 8 cycles heading down.
    idle(2);
    checkOutput("rstDirection", direction, 2'b01);
    checkOutput("rstRunning", running, 1'b0);
    rstN = 1'b1;
    idle(2);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(18);

    // Single key mid-interval, applied at the next step.
    idle(3);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    waitTerminal();
    idle(1);

    // Duplicate/reversal rejection, then fill the queue and overflow it.
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);

    // Key arriving on the pop cycle of a full queue is accepted.
    waitTerminal();
    kd = (mQ.size() > 0) ? {~mQ[$][1], 1'b0} : 2'b10;
    applyStimulus(1'b1, kd, 1'b0, 1'b0, 1'b0);
    idle(24);

    // Speed change mid-count, then pause/resume with an ignored key.
    waitCnt(5);
    speedSel = 2'b01;
    idle(10);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    idle(5);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    idle(8);

    // game_over on the terminal cycle, restart, then reset mid-run.
    kd = {~mDir[1], 1'b0};
    applyStimulus(1'b1, kd, 1'b0, 1'b0, 1'b0);
    waitTerminal();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    idle(3);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(5);
    rstN = 1'b0;
    idle(1);
    checkOutput("midRunReset", {step, direction, running, queue_full, drop}, 6'b001000);
    rstN = 1'b1;
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rstN = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 49) == 0) speedSel = 2'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 49) == 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 89) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/snake_step_scheduler.md
Name: snake_step_scheduler

Overview:
- Sequences snake head motion: generates the periodic game-step pulse and applies buffered direction commands, at most one per step.
- Sits between the keyboard direction decode and the snake body/head datapath.
- Keeps fast successive key presses (e.g. left then up within one step) in order instead of losing them.
- Rejects 180-degree reversals and supports start, pause and game-over.

Parameters:
BASE_PERIOD, 12_500_000, clocks per step at speed_sel=0 (4 steps/s at 50 MHz); must be >= 8
CNT_W, 24, width of step counter; must hold BASE_PERIOD-1
QDEPTH, 2, direction command queue depth (1..4)

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-low
key_valid  in  1  one-cycle pulse, new direction request from keyboard decode
key_dir  in  2  requested direction: 00 up, 01 down, 10 left, 11 right
start  in  1  one-cycle pulse, begin/restart game
pause  in  1  one-cycle pulse, toggle pause
game_over  in  1  collision flag from datapath (level or pulse)
speed_sel  in  2  step period = BASE_PERIOD >> speed_sel
step  out  1  one-cycle pulse, head advances one cell in direction
direction  out  2  current travel direction, same encoding as key_dir
running  out  1  high only in RUN
queue_full  out  1  queue holds QDEPTH entries
drop  out  1  one-cycle pulse, key request discarded

Behaviour:
- Reset (reset=0 at posedge): state IDLE; direction=01 (down); step=0; drop=0; running=0; queue empty; counter=0. Applies from any state, including mid-step.
- States: IDLE, RUN, PAUSED, OVER. All outputs are registered.
- IDLE/OVER: start -> RUN; counter=0, queue flushed, direction=01. Keys, pause and game_over are ignored, with no drop.
- RUN priority: game_over > pause > step/keys.
- RUN + game_over -> OVER; queue flushed; no step that cycle, even if the counter is terminal.
- RUN + pause -> PAUSED; counter holds; no step.
- PAUSED + game_over -> OVER. PAUSED + pause -> RUN; counter resumes from the held value.
- PAUSED ignores key_valid, with no drop. start is ignored in RUN and PAUSED.
- Counter (RUN only): increments each cycle.
  - Terminal when counter >= period-1, with period = BASE_PERIOD >> speed_sel.
  - Using >= makes a speed_sel increase mid-count take effect without overrun.
  - At terminal: counter <= 0 and step <= 1 (step is high the following cycle, exactly one cycle).
  - period=1 gives step every cycle.
- Pop: on the edge that sets step=1, if the queue is non-empty, direction <= queue head and the head is popped. So direction is already updated while step is high. Empty queue leaves direction unchanged.
- Enqueue (RUN only, key_valid=1):
  - ref = queue tail if the queue is non-empty, else direction.
  - Opposite(a,b) is true iff a[1]==b[1] and a[0]!=b[0].
  - Discard with drop=1 next cycle if key_dir==ref, opposite(key_dir,ref), or the queue is full and not popping this cycle.
  - Otherwise push key_dir.
- Simultaneous push and pop: ref is computed before the pop. Push is allowed when full because the pop frees an entry, so occupancy is unchanged. Order is preserved.
- queue_full and running reflect the registered state/occupancy.

Test Plan:
- BASE_PERIOD=8, speed_sel=0, reset low 2 cycles then high, start pulse -> step pulses every 8 cycles, direction=01, running=1, drop never high.
- Single key in RUN: key 10 (left) mid-interval -> direction still 01 until the next step; that step cycle shows direction=10 and the queue empties.
- Reversal and duplicate rejection: direction=01, key 00 -> drop; key 01 -> drop. Then key 10 followed by key 11 in the same interval -> 10 queued, 11 dropped (opposite of tail).
- Queue order and full: direction=01, keys 10, 00, 11 within one interval (QDEPTH=2) -> 10 and 00 queued, 11 dropped, queue_full=1. Next step direction=10, following step 00. A key arriving in the same cycle as the step pop is accepted.
- Speed change and pause: counter=5 with speed_sel switched 0->1 -> step the next cycle, then every 4 cycles. pause pulse -> no step and counter frozen; second pause resumes with the remaining count.
- game_over asserted in the cycle the counter is terminal -> no step, state OVER, running=0, queue flushed. start -> RUN, direction=01. reset low mid-RUN -> all outputs at reset values next cycle.
